// File: rtl/mor1kx_tlb_reload_arbiter.sv
// Shares one TLB-reload bus port between the IMMU and DMMU page-table walkers.
// Grants are held for a whole multi-beat walk; each beat is one registered bus access.
module mor1kx_tlb_reload_arbiter #(
    parameter int    OPTION_OPERAND_WIDTH = 32,
    parameter string FEATURE_ARB_POLICY   = "RR"
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            immu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
    output logic                            immu_ack_o,
    output logic                            immu_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,

    input  logic                            dmmu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
    output logic                            dmmu_ack_o,
    output logic                            dmmu_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,

    output logic                            bus_req_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] bus_addr_o,
    input  logic                            bus_ack_i,
    input  logic                            bus_err_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_i,

    output logic [1:0]                      grant_o
);

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IMMU = 2'b01;
    localparam logic [1:0] GNT_DMMU = 2'b10;
    localparam bit         DMMU_PRIO = (FEATURE_ARB_POLICY == "DMMU");

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                          state, state_next;
    logic [1:0]                      grant, grant_next;
    logic [1:0]                      last_grant, last_grant_next;
    logic                            bus_req_next;
    logic [OPTION_OPERAND_WIDTH-1:0] bus_addr_next;

    logic                            owner_req;
    logic [OPTION_OPERAND_WIDTH-1:0] owner_addr;
    logic [1:0]                      pick;
    logic                            busy;

    assign owner_req  = (grant[0] & immu_req_i) | (grant[1] & dmmu_req_i);
    assign owner_addr = grant[1] ? dmmu_addr_i : immu_addr_i;
    assign busy       = (state == BUSY);

    // Arbitration between fresh requests; a tie goes to whoever was not served last,
    // unless the DMMU has fixed priority.
    always_comb begin
        pick = GNT_NONE;
        if (immu_req_i && dmmu_req_i) begin
            if (DMMU_PRIO || (last_grant == GNT_IMMU))
                pick = GNT_DMMU;
            else
                pick = GNT_IMMU;
        end else if (immu_req_i) begin
            pick = GNT_IMMU;
        end else if (dmmu_req_i) begin
            pick = GNT_DMMU;
        end
    end

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        bus_req_next    = bus_req_o;
        bus_addr_next   = bus_addr_o;
        case (state)
            IDLE: begin
                if (pick != GNT_NONE) begin
                    grant_next    = pick;
                    bus_req_next  = 1'b1;
                    bus_addr_next = pick[1] ? dmmu_addr_i : immu_addr_i;
                    state_next    = BUSY;
                end
            end
            BUSY: begin
                if (bus_ack_i || bus_err_i) begin
                    bus_req_next = 1'b0;
                    state_next   = GAP;
                end
            end
            GAP: begin
                // A still-asserted owner request means the walk has another beat.
                if (owner_req) begin
                    bus_req_next  = 1'b1;
                    bus_addr_next = owner_addr;
                    state_next    = BUSY;
                end else begin
                    last_grant_next = grant;
                    grant_next      = GNT_NONE;
                    state_next      = IDLE;
                end
            end
            default: begin
                bus_req_next = 1'b0;
                grant_next   = GNT_NONE;
                state_next   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= GNT_NONE;
            last_grant <= GNT_IMMU;
            bus_req_o  <= 1'b0;
            bus_addr_o <= '0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
            bus_req_o  <= bus_req_next;
            bus_addr_o <= bus_addr_next;
        end
    end

    // Responses go only to the owner, and only while it still wants the beat.
    assign immu_ack_o  = busy & grant[0] & immu_req_i & bus_ack_i & ~bus_err_i;
    assign immu_err_o  = busy & grant[0] & immu_req_i & bus_err_i;
    assign dmmu_ack_o  = busy & grant[1] & dmmu_req_i & bus_ack_i & ~bus_err_i;
    assign dmmu_err_o  = busy & grant[1] & dmmu_req_i & bus_err_i;
    assign immu_data_o = bus_dat_i;
    assign dmmu_data_o = bus_dat_i;
    assign grant_o     = grant;

endmodule

// File: tb/tb_mor1kx_tlb_reload_arbiter.sv
// Bench for mor1kx_tlb_reload_arbiter: directed walks with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_mor1kx_tlb_reload_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         immu_req, dmmu_req;
    logic [W-1:0] immu_addr, dmmu_addr;
    logic         immu_ack, immu_err, dmmu_ack, dmmu_err;
    logic [W-1:0] immu_data, dmmu_data;
    logic         bus_req;
    logic [W-1:0] bus_addr;
    logic         bus_ack, bus_err;
    logic [W-1:0] bus_dat;
    logic [1:0]   grant;

    // Second instance with fixed DMMU priority, on a bus that acks immediately.
    logic         p_rst, p_ireq, p_dreq;
    logic [W-1:0] p_iaddr, p_daddr;
    logic         p_iack, p_ierr, p_dack, p_derr;
    logic [W-1:0] p_idata, p_ddata;
    logic         p_bus_req;
    logic [W-1:0] p_bus_addr;
    logic         p_bus_ack, p_bus_err;
    logic [W-1:0] p_bus_dat;
    logic [1:0]   p_grant;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who owns the port, whether a beat is on the bus, whether we sit in the
    // one-cycle gap after a beat, and who was served last.
    int           m_owner = 0;
    bit           m_on_bus = 1'b0;
    bit           m_gap = 1'b0;
    int           m_last = 1;
    logic [W-1:0] m_addr = '0;
    bit           ev_i = 1'b0, ev_d = 1'b0;
    int           i_left = 0, d_left = 0, bus_lat = 0;

    always #5 clk = ~clk;

    assign p_bus_ack = p_bus_req;
    assign p_bus_err = 1'b0;

    mor1kx_tlb_reload_arbiter #(.OPTION_OPERAND_WIDTH(W), .FEATURE_ARB_POLICY("RR")) u_dut (
        .clk(clk), .rst(rst),
        .immu_req_i(immu_req), .immu_addr_i(immu_addr), .immu_ack_o(immu_ack),
        .immu_err_o(immu_err), .immu_data_o(immu_data),
        .dmmu_req_i(dmmu_req), .dmmu_addr_i(dmmu_addr), .dmmu_ack_o(dmmu_ack),
        .dmmu_err_o(dmmu_err), .dmmu_data_o(dmmu_data),
        .bus_req_o(bus_req), .bus_addr_o(bus_addr), .bus_ack_i(bus_ack),
        .bus_err_i(bus_err), .bus_dat_i(bus_dat), .grant_o(grant)
    );

    mor1kx_tlb_reload_arbiter #(.OPTION_OPERAND_WIDTH(W), .FEATURE_ARB_POLICY("DMMU")) u_dut_prio (
        .clk(clk), .rst(p_rst),
        .immu_req_i(p_ireq), .immu_addr_i(p_iaddr), .immu_ack_o(p_iack),
        .immu_err_o(p_ierr), .immu_data_o(p_idata),
        .dmmu_req_i(p_dreq), .dmmu_addr_i(p_daddr), .dmmu_ack_o(p_dack),
        .dmmu_err_o(p_derr), .dmmu_data_o(p_ddata),
        .bus_req_o(p_bus_req), .bus_addr_o(p_bus_addr), .bus_ack_i(p_bus_ack),
        .bus_err_i(p_bus_err), .bus_dat_i(p_bus_dat), .grant_o(p_grant)
    );

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] owner_vec(input int who);
        return (who == 1) ? 2'b01 : (who == 2) ? 2'b10 : 2'b00;
    endfunction

    // One clock edge of the reference behaviour, from the values present at the edge.
    task automatic modelStep();
        bit own_req;
        own_req = (m_owner == 1 && immu_req) || (m_owner == 2 && dmmu_req);
        if (rst) begin
            m_owner = 0; m_on_bus = 0; m_gap = 0; m_last = 1; m_addr = '0;
        end else if (m_gap) begin
            m_gap = 0;
            if (own_req) begin
                m_on_bus = 1;
                m_addr   = (m_owner == 1) ? immu_addr : dmmu_addr;
            end else begin
                m_last  = m_owner;
                m_owner = 0;
            end
        end else if (m_on_bus) begin
            if (bus_ack || bus_err) begin
                m_on_bus = 0;
                m_gap    = 1;
            end
        end else if (immu_req || dmmu_req) begin
            m_owner  = (immu_req && dmmu_req) ? 3 - m_last : (immu_req ? 1 : 2);
            m_on_bus = 1;
            m_addr   = (m_owner == 1) ? immu_addr : dmmu_addr;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    // Every-cycle comparison of the main instance against the model.
    initial begin
        bit own_req, e_ack, e_err;
        @(posedge clk);
        forever begin
            @(negedge clk);
            own_req = (m_owner == 1 && immu_req) || (m_owner == 2 && dmmu_req);
            e_ack   = m_on_bus && own_req && bus_ack && !bus_err;
            e_err   = m_on_bus && own_req && bus_err;
            checkOutput("m_bus_req",  {31'd0, bus_req}, {31'd0, m_on_bus});
            checkOutput("m_bus_addr", bus_addr, m_addr);
            checkOutput("m_grant",    {30'd0, grant}, {30'd0, owner_vec(m_owner)});
            checkOutput("m_immu_ack", {31'd0, immu_ack}, {31'd0, e_ack && m_owner == 1});
            checkOutput("m_immu_err", {31'd0, immu_err}, {31'd0, e_err && m_owner == 1});
            checkOutput("m_dmmu_ack", {31'd0, dmmu_ack}, {31'd0, e_ack && m_owner == 2});
            checkOutput("m_dmmu_err", {31'd0, dmmu_err}, {31'd0, e_err && m_owner == 2});
            checkOutput("m_immu_data", immu_data, bus_dat);
            checkOutput("m_dmmu_data", dmmu_data, bus_dat);
            ev_i = (e_ack || e_err) && m_owner == 1;
            ev_d = (e_ack || e_err) && m_owner == 2;
        end
    end

    // Random walkers on both MMU ports plus a bus slave with variable latency.
    task automatic applyStimulus();
        int r;
        if (rst) rst = 1'b0;
        else if ($urandom_range(0, 299) == 0) rst = 1'b1;

        if (immu_req) begin
            if (ev_i) begin
                i_left--;
                if (i_left <= 0) immu_req = 1'b0;
                else immu_addr = $urandom;
            end else if (m_owner == 1 && m_on_bus && $urandom_range(0, 39) == 0) begin
                immu_req = 1'b0;
            end
        end else if ($urandom_range(0, 3) == 0) begin
            immu_req = 1'b1; immu_addr = $urandom; i_left = $urandom_range(1, 3);
        end

        if (dmmu_req) begin
            if (ev_d) begin
                d_left--;
                if (d_left <= 0) dmmu_req = 1'b0;
                else dmmu_addr = $urandom;
            end else if (m_owner == 2 && m_on_bus && $urandom_range(0, 39) == 0) begin
                dmmu_req = 1'b0;
            end
        end else if ($urandom_range(0, 3) == 0) begin
            dmmu_req = 1'b1; dmmu_addr = $urandom; d_left = $urandom_range(1, 3);
        end

        bus_ack = 1'b0; bus_err = 1'b0; bus_dat = $urandom;
        if (m_on_bus) begin
            if (bus_lat == 0) begin
                r = $urandom_range(0, 7);
                bus_err = (r <= 1);
                bus_ack = (r != 0);
                bus_lat = $urandom_range(0, 3);
            end else begin
                bus_lat--;
            end
        end else begin
            bus_lat = $urandom_range(0, 3);
        end
    endtask

    task automatic doReset();
        rst = 1'b1; immu_req = 0; dmmu_req = 0; bus_ack = 0; bus_err = 0; bus_dat = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rst_bus_req",  {31'd0, bus_req}, 32'd0);
        checkOutput("rst_grant",    {30'd0, grant}, 32'd0);
        checkOutput("rst_bus_addr", bus_addr, 32'd0);
    endtask

    initial begin
        rst = 1'b1; immu_req = 0; dmmu_req = 0; immu_addr = '0; dmmu_addr = '0;
        bus_ack = 0; bus_err = 0; bus_dat = '0;
        p_rst = 1'b1; p_ireq = 0; p_dreq = 0; p_iaddr = 32'hA000; p_daddr = 32'hB000;
        p_bus_dat = 32'h5A5A_0000;

        // Single DMMU two-beat walk
        doReset();
        dmmu_req = 1; dmmu_addr = 32'h0000_1040; #1;
        checkOutput("w_idle_grant", {30'd0, grant}, 32'd0);
        tick(); #1;
        checkOutput("w_req1",   {31'd0, bus_req}, 32'd1);
        checkOutput("w_addr1",  bus_addr, 32'h0000_1040);
        checkOutput("w_grant1", {30'd0, grant}, 32'd2);
        tick(); tick();
        bus_ack = 1; bus_dat = 32'h0012_4000; #1;
        checkOutput("w_ack1",   {31'd0, dmmu_ack}, 32'd1);
        checkOutput("w_data1",  dmmu_data, 32'h0012_4000);
        checkOutput("w_iack1",  {31'd0, immu_ack}, 32'd0);
        tick(); bus_ack = 0; dmmu_addr = 32'h0012_4008; #1;
        checkOutput("w_gap_req",   {31'd0, bus_req}, 32'd0);
        checkOutput("w_gap_grant", {30'd0, grant}, 32'd2);
        tick(); #1;
        checkOutput("w_req2",  {31'd0, bus_req}, 32'd1);
        checkOutput("w_addr2", bus_addr, 32'h0012_4008);
        tick();
        bus_ack = 1; bus_dat = 32'h0012_4401; #1;
        checkOutput("w_ack2",  {31'd0, dmmu_ack}, 32'd1);
        checkOutput("w_data2", dmmu_data, 32'h0012_4401);
        tick(); bus_ack = 0; dmmu_req = 0; #1;
        checkOutput("w_gap2_grant", {30'd0, grant}, 32'd2);
        tick(); #1;
        checkOutput("w_rel_grant", {30'd0, grant}, 32'd0);

        // Simultaneous requests: DMMU first, IMMU three cycles after DMMU's ack
        doReset();
        immu_req = 1; immu_addr = 32'h2000; dmmu_req = 1; dmmu_addr = 32'h3000;
        tick(); #1;
        checkOutput("s_grant_d", {30'd0, grant}, 32'd2);
        checkOutput("s_addr_d",  bus_addr, 32'h3000);
        bus_ack = 1; #1;
        checkOutput("s_dack", {31'd0, dmmu_ack}, 32'd1);
        checkOutput("s_iack", {31'd0, immu_ack}, 32'd0);
        tick(); bus_ack = 0; dmmu_req = 0; #1;
        checkOutput("s_gap_grant", {30'd0, grant}, 32'd2);
        tick(); #1;
        checkOutput("s_idle_grant", {30'd0, grant}, 32'd0);
        checkOutput("s_idle_req",   {31'd0, bus_req}, 32'd0);
        dmmu_req = 1; dmmu_addr = 32'h3100;
        tick(); #1;
        checkOutput("s_grant_i", {30'd0, grant}, 32'd1);
        checkOutput("s_req_i",   {31'd0, bus_req}, 32'd1);
        checkOutput("s_addr_i",  bus_addr, 32'h2000);
        bus_ack = 1; #1;
        checkOutput("s_iack2", {31'd0, immu_ack}, 32'd1);
        tick(); bus_ack = 0; immu_req = 0;
        tick(); tick(); #1;
        checkOutput("s_grant_d2", {30'd0, grant}, 32'd2);
        checkOutput("s_addr_d2",  bus_addr, 32'h3100);
        bus_ack = 1;
        tick(); bus_ack = 0; dmmu_req = 0;
        tick(); tick();

        // Abort mid-beat with a pending IMMU request
        doReset();
        dmmu_req = 1; dmmu_addr = 32'h4000;
        tick(); immu_req = 1; immu_addr = 32'h5000; dmmu_req = 0;
        tick(); #1;
        checkOutput("a_req_held", {31'd0, bus_req}, 32'd1);
        checkOutput("a_addr",     bus_addr, 32'h4000);
        checkOutput("a_grant",    {30'd0, grant}, 32'd2);
        bus_ack = 1; #1;
        checkOutput("a_dack", {31'd0, dmmu_ack}, 32'd0);
        checkOutput("a_iack", {31'd0, immu_ack}, 32'd0);
        tick(); bus_ack = 0; #1;
        checkOutput("a_gap_req", {31'd0, bus_req}, 32'd0);
        tick(); #1;
        checkOutput("a_rel_grant", {30'd0, grant}, 32'd0);
        tick(); #1;
        checkOutput("a_next_grant", {30'd0, grant}, 32'd1);
        checkOutput("a_next_addr",  bus_addr, 32'h5000);
        bus_ack = 1;
        tick(); bus_ack = 0; immu_req = 0;
        tick();

        // Simultaneous ack and error, with the request held for a re-issue
        doReset();
        immu_req = 1; immu_addr = 32'h6000;
        tick();
        bus_ack = 1; bus_err = 1; #1;
        checkOutput("e_err", {31'd0, immu_err}, 32'd1);
        checkOutput("e_ack", {31'd0, immu_ack}, 32'd0);
        tick(); bus_ack = 0; bus_err = 0; #1;
        checkOutput("e_gap_req", {31'd0, bus_req}, 32'd0);
        tick(); #1;
        checkOutput("e_reissue", {31'd0, bus_req}, 32'd1);
        checkOutput("e_addr",    bus_addr, 32'h6000);
        bus_ack = 1;
        tick(); bus_ack = 0; immu_req = 0;
        tick();

        // Reset in the middle of a beat
        doReset();
        dmmu_req = 1; dmmu_addr = 32'h7000;
        tick(); rst = 1; dmmu_req = 0;
        tick(); rst = 0; bus_ack = 1; #1;
        checkOutput("r_req",   {31'd0, bus_req}, 32'd0);
        checkOutput("r_grant", {30'd0, grant}, 32'd0);
        checkOutput("r_dack",  {31'd0, dmmu_ack}, 32'd0);
        checkOutput("r_iack",  {31'd0, immu_ack}, 32'd0);
        tick(); bus_ack = 0; dmmu_req = 1; dmmu_addr = 32'h7100;
        tick(); #1;
        checkOutput("r_new_req",  {31'd0, bus_req}, 32'd1);
        checkOutput("r_new_addr", bus_addr, 32'h7100);
        bus_ack = 1;
        tick(); bus_ack = 0; dmmu_req = 0;
        tick();

        // Fixed DMMU priority wins ties even right after serving the DMMU
        tick(); tick(); p_rst = 0;
        for (int round = 0; round < 3; round++) begin
            p_dreq = 1;
            tick(); #1;
            checkOutput("p_solo_grant", {30'd0, p_grant}, 32'd2);
            checkOutput("p_solo_ack",   {31'd0, p_dack}, 32'd1);
            tick(); p_dreq = 0;
            tick(); #1;
            checkOutput("p_idle_grant", {30'd0, p_grant}, 32'd0);
            p_ireq = 1; p_dreq = 1;
            tick(); #1;
            checkOutput("p_tie_grant", {30'd0, p_grant}, 32'd2);
            tick(); p_ireq = 0; p_dreq = 0;
            tick();
        end

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            tick();
            applyStimulus();
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
